// File: rtl/em_stage_if.sv
// Data-memory bus between the EM pipeline stage (master) and the data memory (slave).
// The master issues one request at a time and holds it until the slave acknowledges.
interface em_stage_if;
    logic       dmem_req;
    logic       dmem_we;
    logic [9:0] dmem_addr;
    logic [9:0] dmem_wdata;
    logic [9:0] dmem_rdata;
    logic       dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/em_stage.sv
// Execute/memory pipeline stage: 10-bit ALU, a two-state memory handshake FSM
// (IDLE/WAIT) and a registered writeback port.  While a memory operation is
// outstanding the upstream pipeline register is frozen through 'stall'.
// Optional feature: define EM_TIMEOUT_EN to abort a memory request that is not
// acknowledged within 15 WAIT cycles and raise the sticky mem_err flag.
module em_stage (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    input  logic [9:0]  aluA,
    input  logic [9:0]  aluB,
    input  logic [2:0]  alu_ctrl,
    input  logic [2:0]  dest_addr,
    input  logic        gp_reg_wb,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [9:0]  store_data,
    output logic        stall,
    em_stage_if.master  dmem,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [9:0]  wb_data,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [9:0]  addr_q, addr_d;
    logic [9:0]  wdata_q, wdata_d;
    logic [2:0]  dest_q, dest_d;       // destination of the outstanding load
    logic        gp_q, gp_d;           // writeback request of the outstanding load
    logic        wb_en_q, wb_en_d;
    logic [2:0]  wb_addr_q, wb_addr_d;
    logic [9:0]  wb_data_q, wb_data_d;

    logic [9:0]  alu_res;
    logic [3:0]  shamt;
    logic        mem_op;
    logic        timeout_hit;

`ifdef EM_TIMEOUT_EN
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    // The 15th consecutive un-acknowledged WAIT cycle aborts the request.
    assign timeout_hit = (state_q == WAIT) && !dmem.dmem_ack && (cnt_q == 4'd14);
    assign mem_err     = err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // A simultaneous load and store request is handled as a store.
    assign mem_op = mem_re | mem_we;

    // ALU: all results wrap to 10 bits; shifts of 10..15 yield zero.
    always_comb begin
        alu_res = '0;
        shamt   = aluB[3:0];
        case (alu_ctrl)
            3'b000:  alu_res = aluA + aluB;
            3'b001:  alu_res = aluA - aluB;
            3'b010:  alu_res = aluA & aluB;
            3'b011:  alu_res = aluA | aluB;
            3'b100:  alu_res = aluA ^ aluB;
            3'b101:  alu_res = (shamt > 4'd9) ? 10'd0 : (aluA << shamt);
            3'b110:  alu_res = (shamt > 4'd9) ? 10'd0 : (aluA >> shamt);
            default: alu_res = {9'b0, $signed(aluA) < $signed(aluB)};
        endcase
    end

    // Freeze upstream while a memory op is being issued or awaits its ack; a
    // timed-out op is dropped, so the stall is released on the abort cycle.
    // Reset releases the stall immediately.
    assign stall = reset & ((state_q == IDLE) ? mem_op
                                              : (~dmem.dmem_ack & ~timeout_hit));

    // Next-state logic for the handshake FSM and all registered outputs.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dest_d    = dest_q;
        gp_d      = gp_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
`ifdef EM_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = mem_we;
                    addr_d  = alu_res;
                    wdata_d = store_data;
                    dest_d  = dest_addr;
                    gp_d    = gp_reg_wb;
`ifdef EM_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end else if (gp_reg_wb) begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = dest_addr;
                    wb_data_d = alu_res;
                end
            end
            WAIT: begin
                if (dmem.dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (!we_q && gp_q) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = dest_q;
                        wb_data_d = dmem.dmem_rdata;
                    end
                end
`ifdef EM_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
            gp_q      <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
`ifdef EM_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dest_q    <= dest_d;
            gp_q      <= gp_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
`ifdef EM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_en           = wb_en_q;
    assign wb_addr         = wb_addr_q;
    assign wb_data         = wb_data_q;

endmodule

// File: tb/tb_em_stage.sv
// Testbench for em_stage: instruction-level reference model, memory responder
// with random latency, and a writeback scoreboard checked by a monitor.
module tb_em_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  aluA, aluB, store_data;
    logic [2:0]  alu_ctrl, dest_addr;
    logic        gp_reg_wb, mem_we, mem_re;
    logic        stall, wb_en, mem_err;
    logic [2:0]  wb_addr;
    logic [9:0]  wb_data;

    em_stage_if dmem_bus();

    em_stage dut (
        .clk(clk), .reset(reset), .aluA(aluA), .aluB(aluB), .alu_ctrl(alu_ctrl),
        .dest_addr(dest_addr), .gp_reg_wb(gp_reg_wb), .mem_we(mem_we), .mem_re(mem_re),
        .store_data(store_data), .stall(stall), .dmem(dmem_bus), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [2:0] addr; logic [9:0] data; longint cyc; } wb_exp_t;
    typedef struct { logic we; logic [9:0] addr; logic [9:0] wdata; } mem_exp_t;
    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];

    logic [9:0] tb_mem[1024];
    logic [9:0] model_mem[1024];

    int resp_mode = 1;   // 0 off, 1 normal responder, 2 ack held high continuously
    int resp_delay = 0;
    int resp_cnt = 0;
    bit resp_seen = 1'b0;
    mem_exp_t cur;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference ALU from the arithmetic rules of each operation.
    function automatic int ref_alu(input int op, input int a, input int b);
        int sh, sa, sb, r;
        sh = b % 16;
        sa = (a >= 512) ? a - 1024 : a;
        sb = (b >= 512) ? b - 1024 : b;
        case (op)
            0: r = a + b;
            1: r = a - b + 1024;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sh >= 10) ? 0 : a * (1 << sh);
            6: r = (sh >= 10) ? 0 : a / (1 << sh);
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return r % 1024;
    endfunction

    // Memory responder: checks each request and acknowledges after resp_delay WAIT cycles.
    initial begin
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_mode == 2) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = 10'($urandom);
            end else if (dmem_bus.dmem_ack) begin
                dmem_bus.dmem_ack   = 1'b0;
                dmem_bus.dmem_rdata = 10'($urandom);
                resp_seen = 1'b0;
            end else if (resp_mode == 1 && reset === 1'b1 && dmem_bus.dmem_req) begin
                if (!resp_seen) begin
                    resp_seen = 1'b1;
                    resp_cnt  = 0;
                    if (mem_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL dmem_unexpected_req: dmem_req=1 required 0");
                        cur.we = dmem_bus.dmem_we; cur.addr = dmem_bus.dmem_addr; cur.wdata = dmem_bus.dmem_wdata;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                check("dmem_we",    {31'b0, dmem_bus.dmem_we}, {31'b0, cur.we});
                check("dmem_addr",  {22'b0, dmem_bus.dmem_addr}, {22'b0, cur.addr});
                check("dmem_wdata", {22'b0, dmem_bus.dmem_wdata}, {22'b0, cur.wdata});
                if (resp_cnt >= resp_delay) begin
                    dmem_bus.dmem_ack = 1'b1;
                    if (dmem_bus.dmem_we) tb_mem[dmem_bus.dmem_addr] = dmem_bus.dmem_wdata;
                    else dmem_bus.dmem_rdata = tb_mem[dmem_bus.dmem_addr];
                end else begin
                    resp_cnt++;
                end
            end
        end
    end

    // Writeback monitor: pops the scoreboard on every wb_en pulse, checks hold otherwise.
    logic [2:0] last_addr = '0;
    logic [9:0] last_data = '0;
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (wb_en) begin
                    if (wb_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL wb_unexpected: wb_en=1 required 0 (t=%0t)", $time);
                    end else begin
                        e = wb_q.pop_front();
                        check("wb_addr",  {29'b0, wb_addr}, {29'b0, e.addr});
                        check("wb_data",  {22'b0, wb_data}, {22'b0, e.data});
                        check("wb_cycle", 32'(cyc), 32'(e.cyc));
                        last_addr = e.addr;
                        last_data = e.data;
                    end
                end else begin
                    check("wb_addr_hold", {29'b0, wb_addr}, {29'b0, last_addr});
                    check("wb_data_hold", {22'b0, wb_data}, {22'b0, last_data});
                end
            end else begin
                last_addr = '0;
                last_data = '0;
            end
        end
    end

    // Presents one instruction, holds it while stalled, and records the expected outcome.
    task automatic issue(input int ctrl, input int a, input int b, input int dest, input int gp,
                         input int re, input int we, input int sd, input int delay);
        int res, sc;
        bit is_mem;
        mem_exp_t me;
        wb_exp_t  e;
        res        = ref_alu(ctrl, a, b);
        is_mem     = (re != 0) || (we != 0);
        aluA       = 10'(a);
        aluB       = 10'(b);
        alu_ctrl   = 3'(ctrl);
        dest_addr  = 3'(dest);
        gp_reg_wb  = (gp != 0);
        mem_re     = (re != 0);
        mem_we     = (we != 0);
        store_data = 10'(sd);
        resp_delay = delay;
        if (is_mem) begin
            me.we = (we != 0); me.addr = 10'(res); me.wdata = 10'(sd);
            mem_q.push_back(me);
        end
        sc = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            sc++;
            if (sc > 64) break;
        end
        check("stall_cycles", 32'(sc), is_mem ? 32'(delay + 1) : 32'd0);
        e.addr = 3'(dest);
        e.cyc  = cyc + 1;
        if (!is_mem) begin
            if (gp != 0) begin e.data = 10'(res); wb_q.push_back(e); end
        end else if (we != 0) begin
            model_mem[res] = 10'(sd);
        end else if (gp != 0) begin
            e.data = model_mem[res];
            wb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int kind, a, b, ctrl, req_cycles;
        logic [9:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = 10'($urandom);
            tb_mem[i] = v;
            model_mem[i] = v;
        end
        reset = 1'b0;
        aluA = '0; aluB = '0; alu_ctrl = '0; dest_addr = '0; store_data = '0;
        gp_reg_wb = 1'b0; mem_we = 1'b0; mem_re = 1'b1;
        #12;
        // Reset state (a pending load request must not raise stall during reset)
        check("rst_dmem_req",   {31'b0, dmem_bus.dmem_req}, 32'd0);
        check("rst_dmem_we",    {31'b0, dmem_bus.dmem_we}, 32'd0);
        check("rst_dmem_addr",  {22'b0, dmem_bus.dmem_addr}, 32'd0);
        check("rst_dmem_wdata", {22'b0, dmem_bus.dmem_wdata}, 32'd0);
        check("rst_wb_en",      {31'b0, wb_en}, 32'd0);
        check("rst_wb_addr",    {29'b0, wb_addr}, 32'd0);
        check("rst_wb_data",    {22'b0, wb_data}, 32'd0);
        check("rst_mem_err",    {31'b0, mem_err}, 32'd0);
        check("rst_stall",      {31'b0, stall}, 32'd0);
        mem_re = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Load straight out of reset: addr 5+3=8, three un-acked WAIT cycles, rdata 155
        tb_mem[8] = 10'h155;
        model_mem[8] = 10'h155;
        issue(0, 5, 3, 4, 1, 1, 0, 0, 3);
        // Back-to-back: ALU op directly after the load must not be lost
        issue(0, 10'h3F0, 10'h020, 1, 1, 0, 0, 0, 0);
        // ALU sweep
        for (int op = 0; op < 8; op++) issue(op, 10'h3F0, 10'h020, op, 1, 0, 0, 0, 0);
        // Shift boundary: amounts 9..15 and signed compare corners
        for (int s = 9; s < 16; s++) begin
            issue(5, 10'h001, s, 2, 1, 0, 0, 0, 0);
            issue(6, 10'h200, s, 3, 1, 0, 0, 0, 0);
        end
        issue(7, 10'h200, 10'h1FF, 5, 1, 0, 0, 0, 0);
        issue(7, 10'h1FF, 10'h200, 6, 1, 0, 0, 0, 0);
        // Store with immediate ack, then both re and we (treated as store), then reload
        issue(0, 6, 0, 0, 1, 0, 1, 10'h2AA, 0);
        issue(0, 7, 0, 0, 1, 1, 1, 10'h0F5, 2);
        issue(0, 3, 3, 7, 1, 1, 0, 0, 1);
        issue(0, 7, 0, 6, 1, 1, 0, 0, 0);

        // Acks while IDLE are ignored
        resp_mode = 2;
        issue(1, 100, 1, 1, 1, 0, 0, 0, 0);
        issue(4, 10'h155, 10'h0FF, 2, 1, 0, 0, 0, 0);
        check("idle_ack_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        resp_mode = 1;
        bubble(2);

        // Reset during WAIT aborts the load without writeback
        resp_mode = 0;
        aluA = 10'd1; aluB = 10'd1; alu_ctrl = 3'd0; dest_addr = 3'd2;
        gp_reg_wb = 1'b1; mem_re = 1'b1; mem_we = 1'b0;
        @(posedge clk);
        #1;
        check("wait_req",   {31'b0, dmem_bus.dmem_req}, 32'd1);
        check("wait_stall", {31'b0, stall}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_req",   {31'b0, dmem_bus.dmem_req}, 32'd0);
        check("abort_stall", {31'b0, stall}, 32'd0);
        check("abort_addr",  {22'b0, dmem_bus.dmem_addr}, 32'd0);
        check("abort_wb_en", {31'b0, wb_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        gp_reg_wb = 1'b0; mem_re = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_abort_req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        resp_mode = 1;
        bubble(2);

        // Un-acknowledged store: timeout abort, or indefinite wait without the feature
        resp_mode = 0;
        aluA = 10'd7; aluB = 10'd0; alu_ctrl = 3'd0; store_data = 10'd3;
        gp_reg_wb = 1'b0; mem_we = 1'b1; mem_re = 1'b0;
        @(posedge clk);
        #1;
        req_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!dmem_bus.dmem_req) break;
            req_cycles++;
            if (!stall) mem_we = 1'b0;
        end
        mem_we = 1'b0;
`ifdef EM_TIMEOUT_EN
        check("timeout_req_cycles", 32'(req_cycles), 32'd15);
        check("timeout_mem_err", {31'b0, mem_err}, 32'd1);
        check("timeout_stall",   {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        resp_mode = 1;
        issue(2, 10'h3C3, 10'h0FF, 3, 1, 0, 0, 0, 0);
        check("timeout_err_sticky", {31'b0, mem_err}, 32'd1);
`else
        check("nowait_req_cycles", 32'(req_cycles), 32'd20);
        check("nowait_mem_err", {31'b0, mem_err}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("clear_mem_err", {31'b0, mem_err}, 32'd0);
        check("clear_req",     {31'b0, dmem_bus.dmem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        resp_mode = 1;
        bubble(1);

        // Randomised instruction stream
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                ctrl = $urandom_range(0, 7);
                a = $urandom_range(0, 1023);
                b = (ctrl >= 5 && ctrl <= 6) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
                issue(ctrl, a, b, $urandom_range(0, 7), ($urandom_range(0, 4) != 0), 0, 0, 0, 0);
            end else begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                if (kind == 2)
                    issue(0, a, b, $urandom_range(0, 7), ($urandom_range(0, 4) != 0), 1, 0,
                          $urandom_range(0, 1023), $urandom_range(0, 4));
                else
                    issue(0, a, b, $urandom_range(0, 7), 1, $urandom_range(0, 1), 1,
                          $urandom_range(0, 1023), $urandom_range(0, 4));
            end
        end
        bubble(3);
        check("wb_queue_drained",  32'(wb_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
